// File: rtl/divisor_sequencial_4bits.sv
// divisor_sequencial_4bits
// Sequential 4-bit restoring divider for the ULA datapath.
// An operation is accepted on start in OCIOSO. It runs four shift-and-subtract
// iterations in CALCULA and then presents the result for one cycle in FIM.
// Divide by zero skips CALCULA and goes directly to FIM.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      request, sampled only in OCIOSO
//   a, b       dividend / divisor (4 bits), sampled only at acceptance
//   com_sinal  signed-operation select, sampled at acceptance
//              (exists only with DIVISAO_SINAL_EN)
//   quociente  quotient, registered, holds until the next accepted start
//   resto      remainder, registered, holds until the next accepted start
//   ocupado    high while in CALCULA or FIM
//   pronto     one-cycle pulse while results are presented (FIM)
//   div_zero   divisor of the last accepted operation was zero
//   ov         signed overflow (-8 / -1); tied to 0 without DIVISAO_SINAL_EN
//
// Optional feature macro: DIVISAO_SINAL_EN (two's-complement division,
// truncating; the remainder takes the sign of the dividend).

`timescale 1ns/1ps

module divisor_sequencial_4bits (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
`ifdef DIVISAO_SINAL_EN
  input  logic       com_sinal,
`endif
  output logic [3:0] quociente,
  output logic [3:0] resto,
  output logic       ocupado,
  output logic       pronto,
  output logic       div_zero,
  output logic       ov
);

  localparam int unsigned W  = 4;
  localparam int unsigned IW = 2;

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] CALCULA = 2'd1;
  localparam logic [1:0] FIM     = 2'd2;

  localparam logic [IW-1:0] ITER_LAST = 2'd3;

  // FSM and datapath state
  logic [1:0]    state_q, state_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  b_q, b_d;

  // Next values of the registered outputs
  logic [W-1:0]  quociente_d;
  logic [W-1:0]  resto_d;
  logic          ocupado_d;
  logic          pronto_d;
  logic          div_zero_d;

  // Single-iteration datapath
  logic [W-1:0]  r_sh;
  logic [W-1:0]  q_sh;
  logic [W:0]    trial;
  logic [W-1:0]  r_new;
  logic [W-1:0]  q_new;

  // Operand magnitudes presented to the unsigned core
  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;

  // Final result after any sign correction
  logic [W-1:0]  res_q;
  logic [W-1:0]  res_r;

`ifdef DIVISAO_SINAL_EN
  // Sign bookkeeping captured at acceptance
  logic          neg_a;
  logic          neg_b;
  logic          neg_q_q, neg_q_d;
  logic          neg_r_q, neg_r_d;
  logic          ov_pend_q, ov_pend_d;
  logic          ov_q, ov_d;

  // Magnitudes of the two's-complement operands (-8 maps to 8 as unsigned 4'b1000)
  always_comb begin
    neg_a = com_sinal & a[W-1];
    neg_b = com_sinal & b[W-1];
    mag_a = neg_a ? W'(~a + 4'd1) : a;
    mag_b = neg_b ? W'(~b + 4'd1) : b;
  end

  // Apply the quotient/remainder signs when the result is written
  always_comb begin
    res_q = neg_q_q ? W'(~q_new + 4'd1) : q_new;
    res_r = neg_r_q ? W'(~r_new + 4'd1) : r_new;
  end

  assign ov = ov_q;
`else
  always_comb begin
    mag_a = a;
    mag_b = b;
    res_q = q_new;
    res_r = r_new;
  end

  assign ov = 1'b0;
`endif

  // One restoring step: shift {R,Q} left, then trial subtract with borrow out
  always_comb begin
    r_sh  = {r_q[W-2:0], q_q[W-1]};
    q_sh  = {q_q[W-2:0], 1'b0};
    trial = {1'b0, r_sh} + {1'b1, ~b_q} + 5'd1;
    if (!trial[W]) begin
      r_new = trial[W-1:0];
      q_new = q_sh | 4'd1;
    end else begin
      r_new = r_sh;
      q_new = q_sh;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    q_d         = q_q;
    r_d         = r_q;
    b_d         = b_q;
    quociente_d = quociente;
    resto_d     = resto;
    div_zero_d  = div_zero;
`ifdef DIVISAO_SINAL_EN
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    ov_pend_d   = ov_pend_q;
    ov_d        = ov_q;
`endif

    case (state_q)
      OCIOSO: begin
        if (start) begin
          q_d    = mag_a;
          b_d    = mag_b;
          r_d    = '0;
          iter_d = '0;
`ifdef DIVISAO_SINAL_EN
          neg_q_d   = neg_a ^ neg_b;
          neg_r_d   = neg_a;
          ov_pend_d = com_sinal & (a == 4'b1000) & (b == 4'b1111);
`endif
          if (b == '0) begin
            // Divide by zero: present the fixed result immediately
            state_d     = FIM;
            quociente_d = 4'hF;
            resto_d     = a;
            div_zero_d  = 1'b1;
`ifdef DIVISAO_SINAL_EN
            ov_d        = 1'b0;
`endif
          end else begin
            state_d    = CALCULA;
            div_zero_d = 1'b0;
          end
        end
      end

      CALCULA: begin
        q_d    = q_new;
        r_d    = r_new;
        iter_d = iter_q + 2'd1;
        if (iter_q == ITER_LAST) begin
          state_d     = FIM;
          quociente_d = res_q;
          resto_d     = res_r;
`ifdef DIVISAO_SINAL_EN
          ov_d        = ov_pend_q;
`endif
        end
      end

      FIM: begin
        state_d = OCIOSO;
      end

      default: begin
        state_d = OCIOSO;
      end
    endcase

    // Status outputs are registered copies of the next state
    ocupado_d = (state_d != OCIOSO);
    pronto_d  = (state_d == FIM);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OCIOSO;
      iter_q    <= '0;
      q_q       <= '0;
      r_q       <= '0;
      b_q       <= '0;
      quociente <= '0;
      resto     <= '0;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
      div_zero  <= 1'b0;
`ifdef DIVISAO_SINAL_EN
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      ov_pend_q <= 1'b0;
      ov_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      q_q       <= q_d;
      r_q       <= r_d;
      b_q       <= b_d;
      quociente <= quociente_d;
      resto     <= resto_d;
      ocupado   <= ocupado_d;
      pronto    <= pronto_d;
      div_zero  <= div_zero_d;
`ifdef DIVISAO_SINAL_EN
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      ov_pend_q <= ov_pend_d;
      ov_q      <= ov_d;
`endif
    end
  end

endmodule

// File: tb/tb_divisor_sequencial_4bits.sv
// Bench for divisor_sequencial_4bits: the stimulus pushes the expected results
// into a queue, and a monitor pops and compares them on every pronto pulse.

`timescale 1ns/1ps

module tb_divisor_sequencial_4bits;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       com_sinal;
  logic [3:0] quociente;
  logic [3:0] resto;
  logic       ocupado;
  logic       pronto;
  logic       div_zero;
  logic       ov;

  divisor_sequencial_4bits dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef DIVISAO_SINAL_EN
    .com_sinal (com_sinal),
`endif
    .quociente (quociente),
    .resto     (resto),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .div_zero  (div_zero),
    .ov        (ov)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every pronto pulse consumes one expected result
  always @(negedge clk) begin
    if (pronto === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pronto", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("quociente", int'(quociente), int'(mon_e.q));
        chk("resto",     int'(resto),     int'(mon_e.r));
        chk("div_zero",  int'(div_zero),  int'(mon_e.dz));
        chk("ov",        int'(ov),        int'(mon_e.ov));
      end
    end
  end

  // Issue one operation, scramble a/b after acceptance, and check latency
  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_, input logic sg,
                       input logic [3:0] eq, input logic [3:0] er,
                       input logic edz, input logic eov);
    exp_t e;
    int   busy;
    int   pk;
    e.q  = eq;
    e.r  = er;
    e.dz = edz;
    e.ov = eov;
    sb.push_back(e);
    a         = ta;
    b         = tb_;
    com_sinal = sg;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    a         = 4'h0;
    b         = 4'h0;
    com_sinal = 1'b0;
    busy      = 0;
    pk        = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (pronto === 1'b1 && pk < 0) pk = k;
      if (ocupado === 1'b1) busy++;
      else break;
    end
    chk("busy_cycles",  busy, edz ? 1 : 5);
    chk("pronto_cycle", pk,   edz ? 0 : 4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int npr;
    int first;
    int last;

    // Reset held together with start: reset must win
    rst       = 1'b1;
    start     = 1'b1;
    a         = 4'd3;
    b         = 4'd1;
    com_sinal = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("reset_outputs", int'({quociente, resto, ocupado, pronto, div_zero, ov}), 0);

    // Directed vectors
    do_op(4'd13, 4'd4, 1'b0, 4'd3,  4'd1, 1'b0, 1'b0);
    do_op(4'd15, 4'd1, 1'b0, 4'd15, 4'd0, 1'b0, 1'b0);
    do_op(4'd3,  4'd7, 1'b0, 4'd0,  4'd3, 1'b0, 1'b0);
    do_op(4'd7,  4'd0, 1'b0, 4'hF,  4'd7, 1'b1, 1'b0);
    do_op(4'd9,  4'd3, 1'b0, 4'd3,  4'd0, 1'b0, 1'b0);
    do_op(4'd0,  4'd0, 1'b0, 4'hF,  4'd0, 1'b1, 1'b0);
    do_op(4'd15, 4'd15, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0);

    // Start pulses at edges N+2 and N+5 of an active 6/4 are ignored
    sb.push_back(exp_t'({4'd1, 4'd2, 1'b0, 1'b0}));
    a     = 4'd6;
    b     = 4'd4;
    start = 1'b1;
    @(posedge clk);              // edge N: accepted
    #1 start = 1'b0;
    a = 4'd9;
    b = 4'd0;
    @(posedge clk);              // N+1
    #1 start = 1'b1;
    @(posedge clk);              // N+2: ignored
    #1 start = 1'b0;
    @(posedge clk);              // N+3
    @(posedge clk);              // N+4
    #1 start = 1'b1;
    @(posedge clk);              // N+5: ignored
    #1 start = 1'b0;
    @(negedge clk);
    chk("idle_after_ignored", int'(ocupado), 0);
    repeat (3) @(negedge clk);
    chk("still_idle", int'(ocupado), 0);

    // Start held high: back-to-back operations every 6 cycles
    repeat (3) sb.push_back(exp_t'({4'd2, 4'd1, 1'b0, 1'b0}));
    a     = 4'd5;
    b     = 4'd2;
    start = 1'b1;
    @(posedge clk);              // edge N: first acceptance
    npr   = 0;
    first = -1;
    last  = -1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (pronto === 1'b1) begin
        if (first < 0) first = k;
        else chk("b2b_gap", k - last, 6);
        last = k;
        npr++;
      end
      if (k == 17) start = 1'b0;
    end
    chk("b2b_first", first, 4);
    chk("b2b_count", npr, 3);
    @(negedge clk);
    chk("b2b_idle", int'(ocupado), 0);

    // Reset at edge N+3 of a 12/5 aborts the operation (no expectation pushed)
    a     = 4'd12;
    b     = 4'd5;
    start = 1'b1;
    @(posedge clk);              // N
    #1 start = 1'b0;
    @(posedge clk);              // N+1
    @(posedge clk);              // N+2
    #1 rst = 1'b1;
    @(posedge clk);              // N+3
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", int'({quociente, resto, ocupado, pronto, div_zero, ov}), 0);
    repeat (4) @(negedge clk);
    chk("abort_idle", int'(ocupado), 0);
    do_op(4'd12, 4'd5, 1'b0, 4'd2, 4'd2, 1'b0, 1'b0);

    // Exhaustive unsigned sweep
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 1; bi < 16; bi++) begin
        do_op(4'(ai), 4'(bi), 1'b0, 4'(ai / bi), 4'(ai % bi), 1'b0, 1'b0);
      end
    end

`ifdef DIVISAO_SINAL_EN
    do_op(4'b1001, 4'd2,    1'b1, 4'b1101, 4'b1111, 1'b0, 1'b0);
    do_op(4'b1000, 4'b1111, 1'b1, 4'b1000, 4'd0,    1'b0, 1'b1);
    do_op(4'd6,    4'b1100, 1'b1, 4'b1111, 4'd2,    1'b0, 1'b0);
    do_op(4'b1001, 4'd2,    1'b0, 4'd4,    4'd1,    1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
